rv_fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the RV32I core. It replaces the fetch stage's direct same-cycle array read with a request/response instruction-memory interface. It owns the PC and keeps a prefetch FIFO of {pc, inst} entries. It accepts branch/JAL/JALR redirects from execute and discards stale in-flight fetches. It sits between instruction memory and decode.

---
 rtl/rv_fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 80 ++++++++
 rtl/rv_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_rv_fetch_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and defaults for the RV32I fetch front end.
// Used by rv_fetch_unit and fetch_fifo.
package rv_fetch_pkg;

    localparam int XLEN = 32'd32;
    localparam int ILEN = 32'd32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with occupancy count.
// Flush beats push and pop. A push into a full FIFO is only taken together with a pop.
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int  DEPTH = 32'd4,
    parameter type T     = fetch_entry_t,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 32'd1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  T                 wdata,
    output T                 rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    T                 mem_q [DEPTH];
    T                 mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == CNT_W'(0));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d     = mem_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        if (flush) begin
            rd_ptr_d = PTR_W'(0);
            wr_ptr_d = PTR_W'(0);
            count_d  = CNT_W'(0);
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= PTR_W'(0);
            wr_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rv_fetch_unit.sv
// RV32I fetch front end: owns the PC, issues credit-limited imem requests, queues {pc, inst} for decode.
// Optional macro MISALIGN_CHK_EN: misaligned redirects raise a sticky flag and halt fetch.
module rv_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int              XLEN       = 32'd32,
    parameter int              ADDR_W     = 32'd12,
    parameter int              FIFO_DEPTH = 32'd4,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [XLEN-1:0]   inst_pc,
    output logic              fetch_misalign
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } entry_t;

    // Wide enough that back-to-back redirects with a slow memory cannot wrap the counters.
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 32'd4;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 32'd1;

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic              halted_q, halted_d;
    logic              misalign_q, misalign_d;

    logic [XLEN-1:0]   redir_pc_s;
    logic              misaligned_s;
    logic [CNT_W-1:0]  credit_s;
    logic              req_valid_s, req_fire_s;
    logic              fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
    logic [FCNT_W-1:0] fifo_count_s;
    entry_t            fifo_wdata_s, fifo_rdata_s;

`ifdef MISALIGN_CHK_EN
    assign redir_pc_s   = redirect_pc;
    assign misaligned_s = |redirect_pc[1:0];
`else
    assign redir_pc_s   = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
    assign misaligned_s = 1'b0;
`endif

    // Credit check and handshake decode; responses arriving with a redirect are always stale.
    always_comb begin
        credit_s        = CNT_W'(fifo_count_s) + outstanding_q - drop_q;
        req_valid_s     = reset && !redirect_valid && !halted_q && !fifo_full_s
                          && (credit_s < CNT_W'(FIFO_DEPTH));
        req_fire_s      = req_valid_s && imem_req_ready;
        fifo_push_s     = imem_rsp_valid && (drop_q == CNT_W'(0)) && !redirect_valid;
        fifo_pop_s      = inst_ready;
        fifo_wdata_s.pc   = rsp_pc_q;
        fifo_wdata_s.inst = imem_rsp_data;
    end

    // PC, response-PC tracker, in-flight and drop accounting.
    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire_s) - CNT_W'(imem_rsp_valid);
        drop_d        = drop_q;
        halted_d      = halted_q;
        misalign_d    = misalign_q;
        if (redirect_valid) begin
            pc_d       = redir_pc_s;
            rsp_pc_d   = redir_pc_s;
            drop_d     = outstanding_q - CNT_W'(imem_rsp_valid);
            halted_d   = misaligned_s;
            misalign_d = misaligned_s;
        end else begin
            if (req_fire_s) begin
                pc_d = pc_q + XLEN'(32'd4);
            end else begin
                pc_d = pc_q;
            end
            if (imem_rsp_valid && (drop_q != CNT_W'(0))) begin
                drop_d = drop_q - CNT_W'(1);
            end else if (imem_rsp_valid) begin
                rsp_pc_d = rsp_pc_q + XLEN'(32'd4);
            end else begin
                drop_d = drop_q;
            end
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= CNT_W'(0);
            drop_q        <= CNT_W'(0);
            halted_q      <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            halted_q      <= halted_d;
            misalign_q    <= misalign_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .flush (redirect_valid),
        .wdata (fifo_wdata_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_q[ADDR_W+1:2];
    assign inst_valid     = !fifo_empty_s;
    assign inst_data      = fifo_rdata_s.inst;
    assign inst_pc        = fifo_rdata_s.pc;
    assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed bench for rv_fetch_unit: vector table for streaming/back-pressure, hand sequences for redirects.
// Memory model answers in order after a programmable latency with data = word address * 4.
module tb_rv_fetch_unit;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              reset;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_data;
    logic [31:0]       inst_pc;
    logic              fetch_misalign;

    rv_fetch_unit #(
        .XLEN       (32),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fetch_misalign (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                due;
    } mreq_t;

    typedef struct {
        bit                rst;
        logic              ir;
        logic              mr;
        logic              e_req;
        logic [ADDR_W-1:0] e_addr;
        logic              e_iv;
        logic [31:0]       e_pc;
    } vec_t;

    mreq_t mq[$];
    vec_t  vt[$];
    int    n_checks;
    int    n_fail;
    int    cycle;
    int    lat;

    function automatic vec_t v(bit rst, logic ir, logic mr, logic er, int ea, logic ev, logic [31:0] ep);
        vec_t r;
        r.rst = rst; r.ir = ir; r.mr = mr; r.e_req = er;
        r.e_addr = ADDR_W'(ea); r.e_iv = ev; r.e_pc = ep;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic chk_req(input logic ev, input logic [ADDR_W-1:0] ea);
        chk("imem_req_valid", 32'(imem_req_valid), 32'(ev));
        if (ev) chk("imem_req_addr", 32'(imem_req_addr), 32'(ea));
    endtask

    task automatic chk_inst(input logic ev, input logic [31:0] epc);
        chk("inst_valid", 32'(inst_valid), 32'(ev));
        if (ev) begin
            chk("inst_pc", inst_pc, epc);
            chk("inst_data", inst_data, {18'd0, epc[13:0]});
        end
    endtask

    // Advance one clock: log accepted request, then present any due response.
    task automatic next_cycle();
        logic              fire;
        logic [ADDR_W-1:0] a;
        fire = imem_req_valid && imem_req_ready;
        a    = imem_req_addr;
        if (dut.fifo_push_s && dut.fifo_full_s) begin
            n_fail++;
            $display("FAIL fifo_push_when_full: got push=1 full=1 expected no push (cycle %0d)", cycle);
        end
        @(posedge clk);
        if (fire) mq.push_back('{a, cycle + lat});
        cycle++;
        #1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        if (mq.size() > 0 && mq[0].due <= cycle) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = {18'd0, mq[0].addr, 2'b00};
            void'(mq.pop_front());
        end
    endtask

    // Asynchronous reset, checked immediately; leaves time just after an edge with cycle 1 pending.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", 32'(imem_req_addr), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        chk("rst_misalign", 32'(fetch_misalign), 32'd0);
        mq.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        redirect_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle = 1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cycle = 0; lat = 1;
        reset = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        redirect_valid = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b0;

        // Streaming with a 1-cycle memory: first inst_valid in cycle 3.
        vt.push_back(v(1, 1, 1, 1, 0, 0, 32'h0));
        vt.push_back(v(0, 1, 1, 1, 1, 0, 32'h0));
        vt.push_back(v(0, 1, 1, 1, 2, 1, 32'h0));
        vt.push_back(v(0, 1, 1, 1, 3, 1, 32'h4));
        vt.push_back(v(0, 1, 1, 1, 4, 1, 32'h8));
        vt.push_back(v(0, 1, 1, 1, 5, 1, 32'hC));
        vt.push_back(v(0, 1, 1, 1, 6, 1, 32'h10));
        // Decode stalled: four requests fill the FIFO, then one request per pop.
        vt.push_back(v(1, 0, 1, 1, 0, 0, 32'h0));
        vt.push_back(v(0, 0, 1, 1, 1, 0, 32'h0));
        vt.push_back(v(0, 0, 1, 1, 2, 1, 32'h0));
        vt.push_back(v(0, 0, 1, 1, 3, 1, 32'h0));
        vt.push_back(v(0, 0, 1, 0, 4, 1, 32'h0));
        vt.push_back(v(0, 0, 1, 0, 4, 1, 32'h0));
        vt.push_back(v(0, 1, 1, 0, 4, 1, 32'h0));
        vt.push_back(v(0, 0, 1, 1, 4, 1, 32'h4));
        vt.push_back(v(0, 0, 1, 0, 5, 1, 32'h4));
        vt.push_back(v(0, 0, 1, 0, 5, 1, 32'h4));
        // Memory not ready for 5 cycles: address held, accepted on first ready cycle.
        vt.push_back(v(1, 1, 0, 1, 0, 0, 32'h0));
        vt.push_back(v(0, 1, 0, 1, 0, 0, 32'h0));
        vt.push_back(v(0, 1, 0, 1, 0, 0, 32'h0));
        vt.push_back(v(0, 1, 0, 1, 0, 0, 32'h0));
        vt.push_back(v(0, 1, 0, 1, 0, 0, 32'h0));
        vt.push_back(v(0, 1, 1, 1, 0, 0, 32'h0));
        vt.push_back(v(0, 1, 1, 1, 1, 0, 32'h0));
        vt.push_back(v(0, 1, 1, 1, 2, 1, 32'h0));

        #2;
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst) begin
                lat = 1;
                do_reset();
            end
            inst_ready     = vt[i].ir;
            imem_req_ready = vt[i].mr;
            @(negedge clk);
            chk("imem_req_valid", 32'(imem_req_valid), 32'(vt[i].e_req));
            chk("imem_req_addr", 32'(imem_req_addr), 32'(vt[i].e_addr));
            chk_inst(vt[i].e_iv, vt[i].e_pc);
            next_cycle();
        end

        // Redirect with two requests in flight on a 3-cycle memory.
        lat = 3; do_reset(); inst_ready = 1'b1; imem_req_ready = 1'b1;
        @(negedge clk); chk_req(1'b1, 12'h000); next_cycle();
        @(negedge clk); chk_req(1'b1, 12'h001); next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        @(negedge clk); chk_req(1'b0, 12'h000); chk_inst(1'b0, 32'h0); next_cycle();
        @(negedge clk); chk_req(1'b1, 12'h040); chk_inst(1'b0, 32'h0); next_cycle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk_inst(1'b0, 32'h0); next_cycle();
        end
        @(negedge clk); chk_inst(1'b1, 32'h100); next_cycle();
        @(negedge clk); chk_inst(1'b1, 32'h104); next_cycle();

        // Redirect coinciding with a response and a pop, FIFO holding two entries.
        lat = 2; do_reset(); inst_ready = 1'b0; imem_req_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk_req(1'b1, ADDR_W'(k)); next_cycle();
        end
        @(negedge clk); chk_req(1'b1, 12'h003); chk_inst(1'b1, 32'h0); next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; inst_ready = 1'b1;
        @(negedge clk);
        chk("coincident_rsp_present", 32'(imem_rsp_valid), 32'd1);
        chk_req(1'b0, 12'h000); chk_inst(1'b1, 32'h0); next_cycle();
        @(negedge clk); chk_req(1'b1, 12'h080); chk_inst(1'b0, 32'h0); next_cycle();
        @(negedge clk); chk_inst(1'b0, 32'h0); next_cycle();
        @(negedge clk); chk_inst(1'b0, 32'h0); next_cycle();
        @(negedge clk); chk_inst(1'b1, 32'h200); next_cycle();
        @(negedge clk); chk_inst(1'b1, 32'h204); next_cycle();

        // Misaligned redirect target.
        lat = 1; do_reset(); inst_ready = 1'b1; imem_req_ready = 1'b1;
        @(negedge clk); next_cycle();
        @(negedge clk); next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        @(negedge clk); chk_req(1'b0, 12'h000); next_cycle();
`ifdef MISALIGN_CHK_EN
        @(negedge clk); chk_req(1'b0, 12'h000); chk("fetch_misalign", 32'(fetch_misalign), 32'd1); next_cycle();
        @(negedge clk); chk_req(1'b0, 12'h000); chk_inst(1'b0, 32'h0); next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        @(negedge clk); chk("fetch_misalign_held", 32'(fetch_misalign), 32'd1); next_cycle();
        @(negedge clk); chk("fetch_misalign_clr", 32'(fetch_misalign), 32'd0); chk_req(1'b1, 12'h080); next_cycle();
        @(negedge clk); next_cycle();
        @(negedge clk); chk_inst(1'b1, 32'h200); next_cycle();
`else
        @(negedge clk); chk_req(1'b1, 12'h040); chk("fetch_misalign", 32'(fetch_misalign), 32'd0); next_cycle();
        @(negedge clk); chk_inst(1'b0, 32'h0); next_cycle();
        @(negedge clk); chk_inst(1'b1, 32'h100); next_cycle();
`endif

        // PC and word address wrap at the top of the address space.
        lat = 1; do_reset(); inst_ready = 1'b1; imem_req_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk); chk_req(1'b0, 12'h000); next_cycle();
        @(negedge clk); chk_req(1'b1, 12'hFFF); next_cycle();
        @(negedge clk); chk_req(1'b1, 12'h000); next_cycle();
        @(negedge clk); chk_inst(1'b1, 32'hFFFF_FFFC); next_cycle();
        @(negedge clk); chk_inst(1'b1, 32'h0000_0000); next_cycle();

        // Mid-run asynchronous reset with state loaded.
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
